// File: rtl/conv_pool_engine.sv
// Single-channel conv + ReLU/saturate + 2x2 stride-2 max-pool stage.
// One full KHxKW MAC per cycle during CONV, one pool window per cycle during POOL.
module conv_pool_engine #(
  parameter int IFMAP_HEIGHT  = 128,
  parameter int IFMAP_WIDTH   = 128,
  parameter int KERNEL_HEIGHT = 5,
  parameter int KERNEL_WIDTH  = 5,
  parameter int DATA_WIDTH    = 8,
  parameter int H_STRIDE      = 1,
  parameter int V_STRIDE      = 1,
  parameter int PADDING       = 0,
  localparam int CONV_HEIGHT  = ((IFMAP_HEIGHT + 2 * PADDING - KERNEL_HEIGHT) / V_STRIDE) + 1,
  localparam int CONV_WIDTH   = ((IFMAP_WIDTH + 2 * PADDING - KERNEL_WIDTH) / H_STRIDE) + 1,
  localparam int POOL_HEIGHT  = CONV_HEIGHT / 2,
  localparam int POOL_WIDTH   = CONV_WIDTH / 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] ifmap      [IFMAP_HEIGHT][IFMAP_WIDTH],
  input  logic signed [DATA_WIDTH-1:0] weights    [KERNEL_HEIGHT][KERNEL_WIDTH],
  output logic        [DATA_WIDTH-1:0] conv_ofmap [CONV_HEIGHT][CONV_WIDTH],
  output logic        [DATA_WIDTH-1:0] pool_ofmap [POOL_HEIGHT][POOL_WIDTH],
  output logic                         done_conv,
  output logic                         done_pool
);

  localparam int IHW     = $clog2(IFMAP_HEIGHT > 1 ? IFMAP_HEIGHT : 2);
  localparam int IWW     = $clog2(IFMAP_WIDTH > 1 ? IFMAP_WIDTH : 2);
  localparam int CRW     = $clog2(CONV_HEIGHT > 1 ? CONV_HEIGHT : 2);
  localparam int CCW     = $clog2(CONV_WIDTH > 1 ? CONV_WIDTH : 2);
  localparam int PRW     = $clog2(POOL_HEIGHT > 1 ? POOL_HEIGHT : 2);
  localparam int PCW     = $clog2(POOL_WIDTH > 1 ? POOL_WIDTH : 2);
  localparam int PIX_MAX = (1 << DATA_WIDTH) - 1;

  typedef enum logic [1:0] {StIdle, StConv, StPool, StDone} state_e;

  state_e                 state;
  logic [CRW-1:0]         row;
  logic [CCW-1:0]         col;
  logic [PRW-1:0]         prow;
  logic [PCW-1:0]         pcol;

  logic signed [31:0]           acc;
  logic signed [2*DATA_WIDTH-1:0] prod;
  int                           src_r, src_c;
  logic [DATA_WIDTH-1:0]        pixel;

  int                    r0, r1, c0, c1;
  logic [DATA_WIDTH-1:0] max_top, max_bot, pool_max;

  // Full-kernel MAC for the current (row, col); out-of-frame taps contribute nothing.
  always_comb begin
    acc   = '0;
    prod  = '0;
    src_r = 0;
    src_c = 0;
    for (int i = 0; i < KERNEL_HEIGHT; i++) begin
      for (int j = 0; j < KERNEL_WIDTH; j++) begin
        src_r = int'(row) * V_STRIDE + i - PADDING;
        src_c = int'(col) * H_STRIDE + j - PADDING;
        if (src_r >= 0 && src_r < IFMAP_HEIGHT && src_c >= 0 && src_c < IFMAP_WIDTH) begin
          prod = ifmap[src_r[IHW-1:0]][src_c[IWW-1:0]] * weights[i][j];
          acc  = acc + 32'(prod);
        end
      end
    end
  end

  // ReLU then clamp to the unsigned output range.
  always_comb begin
    if (acc < 0) begin
      pixel = '0;
    end else if (acc > PIX_MAX) begin
      pixel = DATA_WIDTH'(PIX_MAX);
    end else begin
      pixel = acc[DATA_WIDTH-1:0];
    end
  end

  // 2x2 window max over the finished conv map; an odd last row/col is never addressed.
  always_comb begin
    r0       = 2 * int'(prow);
    r1       = r0 + 1;
    c0       = 2 * int'(pcol);
    c1       = c0 + 1;
    max_top  = conv_ofmap[r0[CRW-1:0]][c0[CCW-1:0]];
    if (conv_ofmap[r0[CRW-1:0]][c1[CCW-1:0]] > max_top) begin
      max_top = conv_ofmap[r0[CRW-1:0]][c1[CCW-1:0]];
    end
    max_bot  = conv_ofmap[r1[CRW-1:0]][c0[CCW-1:0]];
    if (conv_ofmap[r1[CRW-1:0]][c1[CCW-1:0]] > max_bot) begin
      max_bot = conv_ofmap[r1[CRW-1:0]][c1[CCW-1:0]];
    end
    pool_max = (max_bot > max_top) ? max_bot : max_top;
  end

  // Frame sequencer: IDLE -> CONV (en-gated) -> POOL (free-running) -> DONE (hold until reset).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= StIdle;
      row       <= '0;
      col       <= '0;
      prow      <= '0;
      pcol      <= '0;
      done_conv <= 1'b0;
      done_pool <= 1'b0;
      for (int i = 0; i < CONV_HEIGHT; i++) begin
        for (int j = 0; j < CONV_WIDTH; j++) begin
          conv_ofmap[i][j] <= '0;
        end
      end
      for (int i = 0; i < POOL_HEIGHT; i++) begin
        for (int j = 0; j < POOL_WIDTH; j++) begin
          pool_ofmap[i][j] <= '0;
        end
      end
    end else begin
      unique case (state)
        StIdle: begin
          if (en) begin
            state <= StConv;
            row   <= '0;
            col   <= '0;
          end
        end
        StConv: begin
          if (en) begin
            conv_ofmap[row][col] <= pixel;
            if (col == CCW'(CONV_WIDTH - 1)) begin
              col <= '0;
              if (row == CRW'(CONV_HEIGHT - 1)) begin
                done_conv <= 1'b1;
                state     <= StPool;
                prow      <= '0;
                pcol      <= '0;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        StPool: begin
          pool_ofmap[prow][pcol] <= pool_max;
          if (pcol == PCW'(POOL_WIDTH - 1)) begin
            pcol <= '0;
            if (prow == PRW'(POOL_HEIGHT - 1)) begin
              done_pool <= 1'b1;
              state     <= StDone;
            end else begin
              prow <= prow + 1'b1;
            end
          end else begin
            pcol <= pcol + 1'b1;
          end
        end
        StDone: begin
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_pool_engine.sv
// Self-checking bench for conv_pool_engine: default-size frames through a scoreboard,
// plus a small padded/strided instance with hand-computed results.
module tb_conv_pool_engine;

  localparam int H  = 128;
  localparam int W  = 128;
  localparam int KH = 5;
  localparam int KW = 5;
  localparam int CH = H - KH + 1;
  localparam int CW = W - KW + 1;
  localparam int PH = CH / 2;
  localparam int PW = CW / 2;

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic signed [7:0] ifmap   [H][W];
  logic signed [7:0] weights [KH][KW];
  logic        [7:0] conv_ofmap [CH][CW];
  logic        [7:0] pool_ofmap [PH][PW];
  logic done_conv, done_pool;

  // Small instance: 6x6, 3x3 kernel, stride 2, padding 1.
  logic en6;
  logic signed [7:0] ifmap6   [6][6];
  logic signed [7:0] weights6 [3][3];
  logic        [7:0] conv6    [3][3];
  logic        [7:0] pool6    [1][1];
  logic done_conv6, done_pool6;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit is_pool;
    int r;
    int c;
    int val;
  } exp_t;
  exp_t sb[$];
  int exp_conv [CH][CW];

  always #5 clk = ~clk;

  conv_pool_engine dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .ifmap      (ifmap),
    .weights    (weights),
    .conv_ofmap (conv_ofmap),
    .pool_ofmap (pool_ofmap),
    .done_conv  (done_conv),
    .done_pool  (done_pool)
  );

  conv_pool_engine #(
    .IFMAP_HEIGHT  (6),
    .IFMAP_WIDTH   (6),
    .KERNEL_HEIGHT (3),
    .KERNEL_WIDTH  (3),
    .DATA_WIDTH    (8),
    .H_STRIDE      (2),
    .V_STRIDE      (2),
    .PADDING       (1)
  ) dut6 (
    .clk        (clk),
    .reset      (reset),
    .en         (en6),
    .ifmap      (ifmap6),
    .weights    (weights6),
    .conv_ofmap (conv6),
    .pool_ofmap (pool6),
    .done_conv  (done_conv6),
    .done_pool  (done_pool6)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int count_nonzero();
    int n = 0;
    for (int i = 0; i < CH; i++) for (int j = 0; j < CW; j++) if (conv_ofmap[i][j] != 0) n++;
    for (int i = 0; i < PH; i++) for (int j = 0; j < PW; j++) if (pool_ofmap[i][j] != 0) n++;
    return n;
  endfunction

  task automatic load_ramp();
    int wrow [KW] = '{1, 0, -1, 0, 1};
    for (int i = 0; i < H; i++) for (int j = 0; j < W; j++) ifmap[i][j] = 8'((i + j) % 256);
    for (int i = 0; i < KH; i++) for (int j = 0; j < KW; j++) weights[i][j] = 8'(wrow[j]);
  endtask

  task automatic load_relu();
    for (int i = 0; i < H; i++) for (int j = 0; j < W; j++) ifmap[i][j] = 8'sd1;
    for (int i = 0; i < KH; i++) for (int j = 0; j < KW; j++) weights[i][j] = -8'sd1;
  endtask

  // Reference model: plain convolution, ReLU, clamp, then 2x2 max; results queued.
  task automatic push_frame();
    exp_t e;
    for (int r = 0; r < CH; r++) begin
      for (int c = 0; c < CW; c++) begin
        int acc = 0;
        for (int i = 0; i < KH; i++)
          for (int j = 0; j < KW; j++)
            acc += int'(ifmap[r + i][c + j]) * int'(weights[i][j]);
        exp_conv[r][c] = (acc < 0) ? 0 : ((acc > 255) ? 255 : acc);
        e = '{is_pool: 1'b0, r: r, c: c, val: exp_conv[r][c]};
        sb.push_back(e);
      end
    end
    for (int r = 0; r < PH; r++) begin
      for (int c = 0; c < PW; c++) begin
        int m = exp_conv[2*r][2*c];
        if (exp_conv[2*r][2*c+1] > m) m = exp_conv[2*r][2*c+1];
        if (exp_conv[2*r+1][2*c] > m) m = exp_conv[2*r+1][2*c];
        if (exp_conv[2*r+1][2*c+1] > m) m = exp_conv[2*r+1][2*c+1];
        e = '{is_pool: 1'b1, r: r, c: c, val: m};
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.is_pool) check($sformatf("pool[%0d][%0d]", e.r, e.c), 32'(pool_ofmap[e.r][e.c]), e.val);
      else           check($sformatf("conv[%0d][%0d]", e.r, e.c), 32'(conv_ofmap[e.r][e.c]), e.val);
    end
  endtask

  // Called just after reset release with en=1; optionally holds en low for pause_len edges.
  task automatic run_frame(input int pause_at, input int pause_len, input int exp_conv_lat);
    int n;
    tick();
    check("done_conv_at_start", 32'(done_conv), 0);
    n = 0;
    while (!done_conv && n < 20000) begin
      if (n == pause_at) en = 1'b0;
      if (n == pause_at + pause_len) en = 1'b1;
      tick();
      n++;
    end
    en = 1'b1;
    check("conv_latency", n, exp_conv_lat);
    check("done_pool_with_conv", 32'(done_pool), 0);
    n = 0;
    while (!done_pool && n < 5000) begin
      tick();
      n++;
    end
    check("pool_latency", n, PH * PW);
  endtask

  task automatic golden();
    check("g_conv00", 32'(conv_ofmap[0][0]), 20);
    check("g_conv01", 32'(conv_ofmap[0][1]), 25);
    check("g_conv11", 32'(conv_ofmap[1][1]), 30);
    check("g_pool00", 32'(pool_ofmap[0][0]), 30);
    check("g_conv24_23", 32'(conv_ofmap[24][23]), 255);
    check("g_conv24_24", 32'(conv_ofmap[24][24]), 255);
  endtask

  initial begin
    int n;
    int exp6 [3][3] = '{'{4, 6, 6}, '{6, 9, 9}, '{6, 9, 9}};
    for (int i = 0; i < 6; i++) for (int j = 0; j < 6; j++) ifmap6[i][j] = 8'sd1;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) weights6[i][j] = 8'sd1;
    en6 = 1'b0;

    // Reset held with en high: everything stays cleared.
    reset = 1'b0;
    en    = 1'b1;
    load_ramp();
    repeat (3) tick();
    check("rst_nonzero", count_nonzero(), 0);
    check("rst_done_conv", 32'(done_conv), 0);
    check("rst_done_pool", 32'(done_pool), 0);

    // Ramp frame with golden and saturating pixels.
    push_frame();
    reset = 1'b1;
    run_frame(-1, 0, CH * CW);
    drain();
    golden();

    // DONE holds regardless of en.
    en = 1'b0;
    repeat (3) tick();
    en = 1'b1;
    repeat (3) tick();
    check("done_hold_conv", 32'(done_conv), 1);
    check("done_hold_pool", 32'(done_pool), 1);
    check("done_hold_pix", 32'(conv_ofmap[0][0]), 20);

    // ReLU frame: all negative accumulations.
    reset = 1'b0;
    tick();
    load_relu();
    push_frame();
    reset = 1'b1;
    run_frame(-1, 0, CH * CW);
    drain();
    check("relu_nonzero", count_nonzero(), 0);

    // Mid-frame reset after 5000 CONV edges.
    reset = 1'b0;
    tick();
    load_ramp();
    reset = 1'b1;
    tick();
    repeat (5000) tick();
    check("mid_written", 32'(count_nonzero() > 0), 1);
    reset = 1'b0;
    #2;
    check("mid_rst_nonzero", count_nonzero(), 0);
    check("mid_rst_done_conv", 32'(done_conv), 0);
    en = 1'b0;
    tick();
    reset = 1'b1;
    repeat (10) tick();
    check("idle_no_progress", count_nonzero(), 0);
    check("idle_done_conv", 32'(done_conv), 0);

    // Rerun with a 100-cycle en=0 pause inside CONV.
    push_frame();
    en = 1'b1;
    run_frame(3000, 100, CH * CW + 100);
    drain();
    golden();

    // Padded, strided small instance.
    reset = 1'b0;
    tick();
    en6   = 1'b1;
    reset = 1'b1;
    tick();
    n = 0;
    while (!done_conv6 && n < 50) begin
      tick();
      n++;
    end
    check("s_conv_latency", n, 9);
    n = 0;
    while (!done_pool6 && n < 50) begin
      tick();
      n++;
    end
    check("s_pool_latency", n, 1);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        check($sformatf("s_conv[%0d][%0d]", i, j), 32'(conv6[i][j]), exp6[i][j]);
    check("s_pool00", 32'(pool6[0][0]), 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
